// File: rtl/pma_pkg.sv
// pma_pkg: shared types for the PMA region table (attributes, field select, rule, cfg FSM state)
package pma_pkg;
  localparam int MaxAddrWidth = 64;
  typedef struct packed {
    logic lock;
    logic valid;
    logic nonidem;
    logic exec;
    logic cached;
  } pma_attr_t;
  typedef enum logic [1:0] {
    field_base    = 2'd0,
    field_length  = 2'd1,
    field_attr    = 2'd2,
    field_illegal = 2'd3
  } cfg_field_e;
  typedef enum logic {
    cfg_idle = 1'b0,
    cfg_resp = 1'b1
  } cfg_state_e;
  typedef struct packed {
    logic [MaxAddrWidth-1:0] base;
    logic [MaxAddrWidth-1:0] length;
    pma_attr_t               attr;
  } pma_rule_t;
endpackage

// File: rtl/pma_range_match.sv
// pma_range_match: single-rule address range comparator, base <= addr < base + length without wrap
// ports: valid (rule enabled), base/length (rule window), addr (lookup address), hit (addr inside window)
module pma_range_match #(
  parameter int AddrWidth = 64
) (
  input  logic                 valid,
  input  logic [AddrWidth-1:0] base,
  input  logic [AddrWidth-1:0] length,
  input  logic [AddrWidth-1:0] addr,
  output logic                 hit
);
  logic [AddrWidth:0] limit;
  assign limit = {1'b0, base} + {1'b0, length};
  assign hit = valid && |length && addr >= base && {1'b0, addr} < limit;
endmodule

// File: rtl/pma_region_table.sv
// pma_region_table: shadow/active PMA rule table with a cfg access port and a 1-cycle lookup port
// ports: clk_i/rst_ni clock and sync active-low reset; cfg_* request/grant/response access to the
//        shadow table, cfg_commit_i copies shadow to active, cfg_dirty_o flags uncommitted writes;
//        lkp_* address lookup against the active table, results one cycle after lkp_valid_i.
// AddrWidth is limited to MaxAddrWidth (64) by the shared rule struct.
module pma_region_table
  import pma_pkg::*;
#(
  parameter int                           NrRules   = 4,
  parameter int                           AddrWidth = 64,
  parameter logic [NrRules*AddrWidth-1:0] RstBase   = '0,
  parameter logic [NrRules*AddrWidth-1:0] RstLength = '0,
  parameter logic [NrRules*5-1:0]         RstAttr   = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_req_i,
  output logic                 cfg_gnt_o,
  input  logic                 cfg_we_i,
  input  logic [3:0]           cfg_idx_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_rvalid_o,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 cfg_commit_i,
  output logic                 cfg_dirty_o,
  input  logic                 lkp_valid_i,
  input  logic [AddrWidth-1:0] lkp_addr_i,
  output logic                 lkp_valid_o,
  output logic                 lkp_hit_o,
  output logic                 lkp_cached_o,
  output logic                 lkp_exec_o,
  output logic                 lkp_nonidem_o
);
  pma_rule_t            shadow_q [NrRules];
  pma_rule_t            active_q [NrRules];
  pma_rule_t            sel;
  cfg_state_e           state_q, state_d;
  cfg_field_e           field;
  logic                 idx_ok, sel_lock, bad, wr_ok, err_q, dirty_q;
  logic [AddrWidth-1:0] rd_field, rdata_q;
  logic [NrRules-1:0]   hits;
  logic                 any_hit, lv_q, hit_q;
  logic [2:0]           hit_res, res_q;

  function automatic pma_rule_t rst_rule(input int i);
    return '{base:   MaxAddrWidth'(RstBase[i*AddrWidth +: AddrWidth]),
             length: MaxAddrWidth'(RstLength[i*AddrWidth +: AddrWidth]),
             attr:   pma_attr_t'(RstAttr[i*5 +: 5])};
  endfunction

  assign field = cfg_field_e'(cfg_field_i);

  // addressed shadow rule plus the lock bit of its active copy; lock is judged on the active table
  always_comb begin
    sel = '0;
    sel_lock = 1'b0;
    idx_ok = 1'b0;
    for (int i = 0; i < NrRules; i++)
      if (cfg_idx_i == 4'(i)) begin
        sel = shadow_q[i];
        sel_lock = active_q[i].attr.lock;
        idx_ok = 1'b1;
      end
  end

  assign bad = !idx_ok || field == field_illegal || (cfg_we_i && sel_lock);
  assign wr_ok = cfg_gnt_o && cfg_we_i && !bad;
  assign rd_field = field == field_base   ? AddrWidth'(sel.base) :
                    field == field_length ? AddrWidth'(sel.length) : AddrWidth'(sel.attr);

  always_ff @(posedge clk_i)
    if (!rst_ni) state_q <= cfg_idle;
    else state_q <= state_d;

  always_comb state_d = state_q == cfg_idle && cfg_req_i ? cfg_resp : cfg_idle;

  always_comb begin
    cfg_gnt_o = state_q == cfg_idle && cfg_req_i;
    cfg_rvalid_o = state_q == cfg_resp;
    cfg_rdata_o = cfg_rvalid_o ? rdata_q : '0;
    cfg_err_o = cfg_rvalid_o && err_q;
  end

  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      err_q <= 1'b0;
      rdata_q <= '0;
    end else if (cfg_gnt_o) begin
      err_q <= bad;
      rdata_q <= bad || cfg_we_i ? '0 : rd_field;
    end

  // commit copies the pre-write shadow; a same-cycle write then lands in shadow and keeps dirty set
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      for (int i = 0; i < NrRules; i++) begin
        shadow_q[i] <= rst_rule(i);
        active_q[i] <= rst_rule(i);
      end
      dirty_q <= 1'b0;
    end else begin
      if (cfg_commit_i)
        for (int i = 0; i < NrRules; i++) begin
          active_q[i] <= shadow_q[i];
          active_q[i].attr.lock <= shadow_q[i].attr.lock | active_q[i].attr.lock;
        end
      for (int i = 0; i < NrRules; i++)
        if (wr_ok && cfg_idx_i == 4'(i)) begin
          if (field == field_base) shadow_q[i].base <= MaxAddrWidth'(cfg_wdata_i);
          if (field == field_length) shadow_q[i].length <= MaxAddrWidth'(cfg_wdata_i);
          if (field == field_attr) shadow_q[i].attr <= pma_attr_t'(cfg_wdata_i[4:0]);
        end
      dirty_q <= wr_ok | (dirty_q & ~cfg_commit_i);
    end

  assign cfg_dirty_o = dirty_q;

  for (genvar g = 0; g < NrRules; g++) begin : g_rule
    pma_range_match #(.AddrWidth(AddrWidth)) u_match (
      .valid (active_q[g].attr.valid),
      .base  (AddrWidth'(active_q[g].base)),
      .length(AddrWidth'(active_q[g].length)),
      .addr  (lkp_addr_i),
      .hit   (hits[g])
    );
  end

  // descending scan so the lowest matching index is the one left standing
  always_comb begin
    any_hit = 1'b0;
    hit_res = '0;
    for (int i = NrRules - 1; i >= 0; i--)
      if (hits[i]) begin
        any_hit = 1'b1;
        hit_res = {active_q[i].attr.nonidem, active_q[i].attr.exec, active_q[i].attr.cached};
      end
  end

  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      lv_q <= 1'b0;
      hit_q <= 1'b0;
      res_q <= '0;
    end else begin
      lv_q <= lkp_valid_i;
      hit_q <= lkp_valid_i && any_hit;
      res_q <= lkp_valid_i && any_hit ? hit_res : '0;
    end

  assign lkp_valid_o = lv_q;
  assign lkp_hit_o = hit_q;
  assign {lkp_nonidem_o, lkp_exec_o, lkp_cached_o} = res_q;
endmodule

// File: tb/tb_pma_region_table.sv
// tb_pma_region_table: directed and randomized checks of pma_region_table against a behavioural table model
module tb_pma_region_table;
  localparam int NR = 4;
  localparam int AW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          cfg_req = 1'b0, cfg_we = 1'b0, cfg_commit = 1'b0, lkp_valid = 1'b0;
  logic [3:0]    cfg_idx = '0;
  logic [1:0]    cfg_field = '0;
  logic [AW-1:0] cfg_wdata = '0, lkp_addr = '0;
  logic          cfg_gnt, cfg_rvalid, cfg_err, cfg_dirty, lkp_vo, lkp_hit, lkp_cached, lkp_exec, lkp_nonidem;
  logic [AW-1:0] cfg_rdata;

  logic          r_lkp_valid = 1'b0;
  logic [AW-1:0] r_lkp_addr = '0;
  logic          r_gnt, r_rvalid, r_err, r_dirty, r_lv, r_hit, r_cached, r_exec, r_nonidem;
  logic [AW-1:0] r_rdata;

  pma_region_table #(.NrRules(NR), .AddrWidth(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_req_i(cfg_req), .cfg_gnt_o(cfg_gnt), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
    .cfg_field_i(cfg_field), .cfg_wdata_i(cfg_wdata), .cfg_rvalid_o(cfg_rvalid),
    .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err), .cfg_commit_i(cfg_commit), .cfg_dirty_o(cfg_dirty),
    .lkp_valid_i(lkp_valid), .lkp_addr_i(lkp_addr), .lkp_valid_o(lkp_vo), .lkp_hit_o(lkp_hit),
    .lkp_cached_o(lkp_cached), .lkp_exec_o(lkp_exec), .lkp_nonidem_o(lkp_nonidem)
  );

  pma_region_table #(
    .NrRules(2), .AddrWidth(AW),
    .RstBase({64'h8000_0000, 64'h0}),
    .RstLength({64'h4000_0000, 64'h1000}),
    .RstAttr({5'h09, 5'h00})
  ) u_rst (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_req_i(1'b0), .cfg_gnt_o(r_gnt), .cfg_we_i(1'b0), .cfg_idx_i(4'h0),
    .cfg_field_i(2'h0), .cfg_wdata_i(64'h0), .cfg_rvalid_o(r_rvalid),
    .cfg_rdata_o(r_rdata), .cfg_err_o(r_err), .cfg_commit_i(1'b0), .cfg_dirty_o(r_dirty),
    .lkp_valid_i(r_lkp_valid), .lkp_addr_i(r_lkp_addr), .lkp_valid_o(r_lv), .lkp_hit_o(r_hit),
    .lkp_cached_o(r_cached), .lkp_exec_o(r_exec), .lkp_nonidem_o(r_nonidem)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: two plain tables of rules plus the expected registered outputs
  bit [63:0] m_sb [16], m_sl [16], m_ab [16], m_al [16];
  bit [4:0]  m_sa [16], m_aa [16];
  bit        m_pend, m_dirty, started;
  bit        e_rv, e_err, e_lv, e_hit, e_c, e_x, e_n;
  bit [63:0] e_rd;

  function automatic bit in_rule(input bit [63:0] b, input bit [63:0] l, input bit [4:0] at, input bit [63:0] a);
    bit [64:0] lim;
    lim = {1'b0, b} + {1'b0, l};
    return at[3] && l != 0 && a >= b && {1'b0, a} < lim;
  endfunction

  always @(posedge clk) begin
    bit g, bad;
    started = 1'b1;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_sb[i] = 0; m_sl[i] = 0; m_sa[i] = 0;
        m_ab[i] = 0; m_al[i] = 0; m_aa[i] = 0;
      end
      m_pend = 0; m_dirty = 0;
      {e_rv, e_err, e_lv, e_hit, e_c, e_x, e_n} = '0;
      e_rd = 0;
    end else begin
      g = !m_pend && cfg_req;
      e_lv = lkp_valid;
      {e_hit, e_c, e_x, e_n} = '0;
      if (lkp_valid)
        for (int i = NR - 1; i >= 0; i--)
          if (in_rule(m_ab[i], m_al[i], m_aa[i], lkp_addr)) begin
            e_hit = 1; e_c = m_aa[i][0]; e_x = m_aa[i][1]; e_n = m_aa[i][2];
          end
      bad = cfg_idx >= NR || cfg_field == 3 || (cfg_we && m_aa[cfg_idx][4]);
      e_rv = g;
      e_err = g && bad;
      e_rd = 0;
      if (g && !bad && !cfg_we)
        e_rd = cfg_field == 0 ? m_sb[cfg_idx] : cfg_field == 1 ? m_sl[cfg_idx] : 64'(m_sa[cfg_idx]);
      if (cfg_commit)
        for (int i = 0; i < NR; i++) begin
          m_ab[i] = m_sb[i]; m_al[i] = m_sl[i];
          m_aa[i] = m_sa[i] | (m_aa[i] & 5'h10);
        end
      if (g && cfg_we && !bad) begin
        if (cfg_field == 0) m_sb[cfg_idx] = cfg_wdata;
        if (cfg_field == 1) m_sl[cfg_idx] = cfg_wdata;
        if (cfg_field == 2) m_sa[cfg_idx] = cfg_wdata[4:0];
        m_dirty = 1;
      end else if (cfg_commit) m_dirty = 0;
      m_pend = g;
    end
  end

  always @(negedge clk)
    if (started) begin
      chk("gnt", cfg_gnt, !m_pend && cfg_req);
      chk("rvalid", cfg_rvalid, e_rv);
      chk("rdata", cfg_rdata, e_rd);
      chk("err", cfg_err, e_err);
      chk("dirty", cfg_dirty, m_dirty);
      chk("lookup", {lkp_vo, lkp_hit, lkp_cached, lkp_exec, lkp_nonidem}, {e_lv, e_hit, e_c, e_x, e_n});
    end

  // tasks start and end 2 time units after a rising edge
  task automatic cfg(input bit we, input bit [3:0] idx, input bit [1:0] fld, input bit [63:0] wd,
                     output bit [63:0] rd, output bit er);
    bit g = 0;
    cfg_req = 1; cfg_we = we; cfg_idx = idx; cfg_field = fld; cfg_wdata = wd;
    for (int n = 0; n < 4 && !g; n++) begin
      @(negedge clk);
      g = cfg_gnt;
      if (!g) begin @(posedge clk); #2; end
    end
    chk("cfg_grant", g, 1);
    @(posedge clk); #2;
    cfg_req = 0; cfg_we = 0;
    @(negedge clk);
    rd = cfg_rdata; er = cfg_err;
    chk("cfg_resp_valid", cfg_rvalid, 1);
    @(posedge clk); #2;
  endtask

  task automatic wr(input bit [3:0] idx, input bit [1:0] fld, input bit [63:0] wd);
    bit [63:0] rd;
    bit er;
    cfg(1, idx, fld, wd, rd, er);
    chk("write_err", er, 0);
  endtask

  task automatic lk(input bit [63:0] a, output bit [3:0] res);
    lkp_valid = 1; lkp_addr = a;
    @(posedge clk); #2;
    lkp_valid = 0;
    @(negedge clk);
    res = {lkp_hit, lkp_cached, lkp_exec, lkp_nonidem};
    @(posedge clk); #2;
  endtask

  task automatic commit();
    cfg_commit = 1;
    @(posedge clk); #2;
    cfg_commit = 0;
  endtask

  initial begin
    bit [3:0] res;
    bit [63:0] rd;
    bit er;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_dirty", cfg_dirty, 0);
    chk("rst_rvalid", cfg_rvalid, 0);
    chk("rst_tbl_idle", {r_gnt, r_rvalid, r_err, r_dirty, r_exec, r_nonidem}, 0);
    chk("rst_tbl_rdata", r_rdata, 0);
    @(posedge clk); #2;
    r_lkp_valid = 1; r_lkp_addr = 64'h8000_0010;
    @(posedge clk); #2;
    r_lkp_addr = 64'h4000_0000;
    @(negedge clk);
    chk("rst_tbl_hit", {r_lv, r_hit, r_cached}, 3'b111);
    @(posedge clk); #2;
    r_lkp_valid = 0;
    @(negedge clk);
    chk("rst_tbl_miss", {r_lv, r_hit}, 2'b10);
    @(posedge clk); #2;

    wr(0, 0, 64'h1_0000); wr(0, 1, 64'h1_0000); wr(0, 2, 64'h0A);
    lk(64'h1_0004, res);
    chk("pre_commit_hit", res[3], 0);
    chk("dirty_after_write", cfg_dirty, 1);
    commit();
    lk(64'h1_0004, res);
    chk("post_commit_hit_exec", {res[3], res[1]}, 2'b11);
    chk("dirty_after_commit", cfg_dirty, 0);
    cfg(0, 0, 1, 0, rd, er);
    chk("read_len", rd, 64'h1_0000);

    wr(1, 0, 64'hFFFF_FFFF_FFFF_F000); wr(1, 1, 64'h1000); wr(1, 2, 64'h08);
    commit();
    lk(64'hFFFF_FFFF_FFFF_FFFF, res);
    chk("top_addr_hit", res[3], 1);
    lk(64'h0, res);
    chk("zero_addr_miss", res[3], 0);
    lk(64'hFFFF_FFFF_FFFF_EFFF, res);
    chk("below_base_miss", res[3], 0);

    wr(2, 0, 64'h2000_0000); wr(2, 1, 64'h100); wr(2, 2, 64'h0C);
    cfg_req = 1; cfg_we = 1; cfg_idx = 3; cfg_field = 0; cfg_wdata = 64'h3000_0000;
    cfg_commit = 1; lkp_valid = 1; lkp_addr = 64'h2000_0000;
    @(negedge clk);
    chk("sim_gnt", cfg_gnt, 1);
    @(posedge clk); #2;
    cfg_req = 0; cfg_we = 0; cfg_commit = 0; lkp_valid = 0;
    @(negedge clk);
    chk("sim_old_lookup", lkp_hit, 0);
    chk("sim_dirty", cfg_dirty, 1);
    chk("sim_err", cfg_err, 0);
    @(posedge clk); #2;
    lk(64'h2000_0000, res);
    chk("sim_new_lookup", {res[3], res[0]}, 2'b11);
    cfg(0, 3, 0, 0, rd, er);
    chk("sim_shadow_write", rd, 64'h3000_0000);
    cfg(0, 5, 0, 0, rd, er);
    chk("idx5_err", {er, rd}, {1'b1, 64'h0});
    cfg(0, 0, 3, 0, rd, er);
    chk("field3_err", er, 1);

    wr(0, 2, 64'h18);
    commit();
    cfg(1, 0, 1, 64'h55, rd, er);
    chk("locked_write_err", er, 1);
    cfg(0, 0, 1, 0, rd, er);
    chk("locked_len_kept", rd, 64'h1_0000);
    commit();
    cfg(1, 0, 2, 64'h00, rd, er);
    chk("lock_sticky", er, 1);

    for (int c = 0; c < 3000; c++) begin
      rst_n = $urandom_range(0, 199) != 0;
      cfg_req = 1'($urandom_range(0, 1));
      cfg_we = 1'($urandom_range(0, 1));
      cfg_idx = 4'($urandom_range(0, 5));
      cfg_field = 2'($urandom_range(0, 3));
      cfg_commit = $urandom_range(0, 7) == 0;
      cfg_wdata = cfg_field == 2 ? 64'({$urandom_range(0, 31) == 0, 4'($urandom)}) :
                  cfg_field == 1 ? 64'($urandom_range(0, 3)) << 8 : 64'($urandom_range(0, 15)) << 8;
      if ($urandom_range(0, 15) == 0 && cfg_field == 0) cfg_wdata = ~64'h0 - 64'($urandom_range(0, 511));
      lkp_valid = 1'($urandom_range(0, 1));
      lkp_addr = $urandom_range(0, 7) == 0 ? ~64'h0 - 64'($urandom_range(0, 255)) : 64'($urandom_range(0, 4095));
      @(posedge clk); #2;
    end
    rst_n = 1; cfg_req = 0; cfg_commit = 0; lkp_valid = 0;
    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
